// File: rtl/armleocpu_imem_responder_pkg.sv
// Shared cache command/response encodings, instruction constants and the
// responder FSM state type used by the instruction-memory responder.
package armleocpu_imem_responder_pkg;

  localparam int CACHE_CMD_W  = 4;
  localparam int CACHE_RESP_W = 4;

  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_NONE      = 4'd0;
  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_EXECUTE   = 4'd1;
  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_FLUSH_ALL = 4'd4;

  localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_IDLE        = 4'd0;
  localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_WAIT        = 4'd1;
  localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_DONE        = 4'd2;
  localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
  localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_MISSALIGNED = 4'd4;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMEM_INIT,
    IMEM_IDLE,
    IMEM_BUSY,
    IMEM_FLUSH,
    IMEM_RESP
  } imem_state_t;

  // 33-bit offset so addresses below the base never wrap back into range.
  function automatic logic imem_addr_in_range(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int          depth_log2);
    logic [32:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return (offset[32] == 1'b0) && (offset < (33'd4 << depth_log2));
  endfunction

endpackage

// File: rtl/armleocpu_imem_responder_ram.sv
// Word-wide instruction storage: one combinational read port and one
// synchronous write port; contents are never cleared by reset.
module armleocpu_imem_ram
  import armleocpu_imem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [31:0]           wr_data
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/armleocpu_imem_responder.sv
// Instruction-memory responder answering cache EXECUTE / FLUSH_ALL commands.
// Define ARMLEOCPU_IMEM_WAIT_STATES_EN to insert WAIT cycles; otherwise every command answers next cycle.
module armleocpu_imem_responder
  import armleocpu_imem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          DEPTH_LOG2   = 10,
  parameter int          WAIT_CYCLES  = 2,
  parameter int          INIT_CYCLES  = 8,
  parameter int          FLUSH_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CACHE_CMD_W-1:0]  c_cmd,
  input  logic [31:0]             c_address,
  output logic [CACHE_RESP_W-1:0] c_response,
  output logic                    c_reset_done,
  output logic [31:0]             c_load_data,
  input  logic                    w_en,
  input  logic [31:0]             w_addr,
  input  logic [31:0]             w_data
);

  localparam int INIT_CNT_W = 16;

  imem_state_t             state_q, state_d;
  logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic                    reset_done_q, reset_done_d;
  logic [CACHE_RESP_W-1:0] resp_q, resp_d;
  logic [31:0]             load_data_q, load_data_d;
  logic [31:0]             word_q, word_d;

  logic                  accept;
  logic                  rd_aligned;
  logic                  rd_in_range;
  logic                  wr_ok;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           rd_data;

  assign rd_idx      = DEPTH_LOG2'((c_address - BASE_ADDR) >> 2);
  assign wr_idx      = DEPTH_LOG2'((w_addr - BASE_ADDR) >> 2);
  assign rd_aligned  = (c_address[1:0] == 2'b00);
  assign rd_in_range = imem_addr_in_range(c_address, BASE_ADDR, DEPTH_LOG2);
  assign wr_ok       = w_en && (w_addr[1:0] == 2'b00)
                       && imem_addr_in_range(w_addr, BASE_ADDR, DEPTH_LOG2);

  armleocpu_imem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .rd_idx (rd_idx),
    .rd_data(rd_data),
    .wr_en  (wr_ok),
    .wr_idx (wr_idx),
    .wr_data(w_data)
  );

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    reset_done_d = reset_done_q;
    resp_d       = CACHE_RESPONSE_IDLE;
    load_data_d  = load_data_q;
    word_d       = word_q;
    accept       = 1'b0;

    case (state_q)
      IMEM_INIT: begin
        if (init_cnt_q == INIT_CNT_W'(INIT_CYCLES - 1)) begin
          state_d      = IMEM_IDLE;
          reset_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      IMEM_IDLE, IMEM_RESP: begin
        accept = 1'b1;
      end
      IMEM_BUSY: begin
        if (wait_cnt_q == 4'(WAIT_CYCLES)) begin
          state_d     = IMEM_RESP;
          resp_d      = CACHE_RESPONSE_DONE;
          load_data_d = word_q;
        end else begin
          resp_d     = CACHE_RESPONSE_WAIT;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      IMEM_FLUSH: begin
        if (wait_cnt_q == 4'(FLUSH_CYCLES)) begin
          state_d     = IMEM_RESP;
          resp_d      = CACHE_RESPONSE_DONE;
          load_data_d = INSTR_NOP;
        end else begin
          resp_d     = CACHE_RESPONSE_WAIT;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IMEM_INIT;
      end
    endcase

    // The word is captured on acceptance so later backdoor writes cannot leak into it.
    if (accept) begin
      state_d = IMEM_IDLE;
      case (c_cmd)
        CACHE_CMD_EXECUTE: begin
          if (!rd_aligned) begin
            state_d = IMEM_RESP;
            resp_d  = CACHE_RESPONSE_MISSALIGNED;
          end else if (!rd_in_range) begin
            state_d = IMEM_RESP;
            resp_d  = CACHE_RESPONSE_ACCESSFAULT;
          end else begin
`ifdef ARMLEOCPU_IMEM_WAIT_STATES_EN
            state_d    = IMEM_BUSY;
            resp_d     = CACHE_RESPONSE_WAIT;
            wait_cnt_d = 4'd1;
            word_d     = rd_data;
`else
            state_d     = IMEM_RESP;
            resp_d      = CACHE_RESPONSE_DONE;
            load_data_d = rd_data;
`endif
          end
        end
        CACHE_CMD_FLUSH_ALL: begin
`ifdef ARMLEOCPU_IMEM_WAIT_STATES_EN
          state_d    = IMEM_FLUSH;
          resp_d     = CACHE_RESPONSE_WAIT;
          wait_cnt_d = 4'd1;
`else
          state_d     = IMEM_RESP;
          resp_d      = CACHE_RESPONSE_DONE;
          load_data_d = INSTR_NOP;
`endif
        end
        CACHE_CMD_NONE: begin
          resp_d = CACHE_RESPONSE_IDLE;
        end
        default: begin
          resp_d = CACHE_RESPONSE_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IMEM_INIT;
      init_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      reset_done_q <= 1'b0;
      resp_q       <= CACHE_RESPONSE_IDLE;
      load_data_q  <= '0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      reset_done_q <= reset_done_d;
      resp_q       <= resp_d;
      load_data_q  <= load_data_d;
      word_q       <= word_d;
    end
  end

  assign c_response   = resp_q;
  assign c_reset_done = reset_done_q;
  assign c_load_data  = load_data_q;

endmodule

// File: doc/armleocpu_imem_responder.md
ARMLEOCPU_IMEM_RESPONDER -- requirements
Module: armleocpu_imem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_2000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra WAIT cycles per EXECUTE, range 1..15.
REQ-004 SHALL have parameter INIT_CYCLES, default 8, cycles c_reset_done stays low after reset.
REQ-005 SHALL have parameter FLUSH_CYCLES, default 4, WAIT cycles before FLUSH_ALL completes, range 1..15.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 c_cmd  in  4  cache command (NONE / EXECUTE / FLUSH_ALL).
REQ-009 c_address  in  32  fetch byte address, sampled with c_cmd.
REQ-010 c_response  out  4  registered response (IDLE / WAIT / DONE / ACCESSFAULT / MISSALIGNED).
REQ-011 c_reset_done  out  1  high once initialisation completes.
REQ-012 c_load_data  out  32  instruction word; valid only while c_response is DONE.
REQ-013 w_en  in  1  backdoor write strobe for program loading.
REQ-014 w_addr  in  32  backdoor byte address.
REQ-015 w_data  in  32  backdoor write data.

Function
REQ-016 SHALL implement states INIT, IDLE, BUSY, FLUSH, RESP.
REQ-017 INIT: count INIT_CYCLES, then enter IDLE and set c_reset_done to 1; commands ignored.
REQ-018 Commands SHALL be accepted only in IDLE or RESP; c_cmd in BUSY, FLUSH or INIT SHALL be ignored.
REQ-019 Accepted EXECUTE, address[1:0]!=0: next cycle c_response=MISSALIGNED for 1 cycle (RESP).
REQ-020 Accepted EXECUTE, aligned, outside [BASE_ADDR, BASE_ADDR+4*2^DEPTH_LOG2): next cycle ACCESSFAULT for 1 cycle; misaligned takes priority.
REQ-021 Accepted EXECUTE, valid: enter BUSY, emit WAIT for exactly WAIT_CYCLES cycles, then DONE with the word for 1 cycle.
REQ-022 The word SHALL be read at acceptance; a backdoor write to the same address during BUSY SHALL NOT alter the returned word.
REQ-023 Accepted FLUSH_ALL: emit WAIT for FLUSH_CYCLES cycles, then DONE for 1 cycle with c_load_data=32'h0000_0013 (NOP).
REQ-024 In RESP, a new command on the same cycle SHALL be accepted (back-to-back); otherwise the next cycle returns IDLE.
REQ-025 NONE, or an undefined c_cmd encoding, in IDLE/RESP: c_response=IDLE next cycle, no state change.
REQ-026 c_load_data SHALL hold its last value outside DONE.
REQ-027 w_en with an aligned in-range w_addr SHALL write the word at the clock edge; other writes SHALL be dropped silently, in any state.
REQ-028 Address arithmetic SHALL be 32-bit unsigned; the index is (c_address-BASE_ADDR)>>2, with no wrap-around into range.

Reset
REQ-029 rst SHALL force state=INIT, c_reset_done=0, c_response=IDLE, c_load_data=0, counters=0, asynchronously.
REQ-030 Reset mid-BUSY or mid-FLUSH SHALL abort the transaction with no DONE emitted; memory contents are not cleared.

Configuration
REQ-031 Macro ARMLEOCPU_IMEM_WAIT_STATES_EN defined: WAIT_CYCLES and FLUSH_CYCLES apply as above.
REQ-032 Macro undefined: BUSY and FLUSH are omitted, EXECUTE and FLUSH_ALL answer on the next cycle (DONE, ACCESSFAULT or MISSALIGNED), and WAIT is never emitted.

Structure
REQ-033 Cache command and response encodings and the NOP constant SHALL come from the shared cache/instruction definitions, not be redefined locally.
REQ-034 Storage SHALL be the sub-module armleocpu_imem_ram: 1 read port and 1 write port, synchronous write, combinational read.

Verification
REQ-035 Reset release: c_reset_done=0 for 8 cycles, then 1; EXECUTE during INIT yields IDLE.
REQ-036 Backdoor write 0x2004<=0xDEADBEEF; EXECUTE 0x2004 -> WAIT, WAIT, DONE with 0xDEADBEEF, then IDLE.
REQ-037 EXECUTE 0x2006 -> MISSALIGNED next cycle; EXECUTE 0x1FFC and 0x3000 (DEPTH_LOG2=10) -> ACCESSFAULT.
REQ-038 EXECUTE 0x2000 reissued on each DONE cycle, then 0x2004 -> back-to-back transactions, no idle gap.
REQ-039 FLUSH_ALL -> 4 WAIT cycles, then DONE with 0x00000013; EXECUTE during FLUSH is ignored.
REQ-040 rst asserted on the second WAIT of an EXECUTE -> no DONE appears; INIT sequence restarts.
